// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and the per-entry record carried in every slot.
package rob_pkg;
   localparam int ROB_ENTRIES = 8;
   localparam int ROB_IDX_W   = 3;
   localparam int ROB_DATA_W  = 32;
   localparam int ROB_RD_W    = 5;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic [ROB_DATA_W-1:0] pc;
      logic [ROB_DATA_W-1:0] val;
      logic [ROB_RD_W-1:0]   rd;
      logic                  write;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Pipeline-side bundle of the reorder buffer: allocate, two writeback ports, commit, bypass lookup.
interface reorder_buffer_if #(
   parameter int IDX_W  = 3,
   parameter int DATA_W = 32
) ();
   logic              flush;
   logic              alloc_req;
   logic [DATA_W-1:0] alloc_pc;
   logic              alloc_ready;
   logic [IDX_W-1:0]  alloc_index;
   logic              wb0_valid;
   logic [IDX_W-1:0]  wb0_index;
   logic [DATA_W-1:0] wb0_val;
   logic [4:0]        wb0_rd;
   logic              wb0_write;
   logic              wb1_valid;
   logic [IDX_W-1:0]  wb1_index;
   logic [DATA_W-1:0] wb1_val;
   logic [4:0]        wb1_rd;
   logic              wb1_write;
   logic              commit_valid;
   logic [4:0]        commit_rd;
   logic [DATA_W-1:0] commit_val;
   logic              commit_write;
   logic [DATA_W-1:0] commit_pc;
   logic [4:0]        lookup_rd;
   logic              lookup_hit;
   logic [DATA_W-1:0] lookup_val;
   logic [IDX_W:0]    count;

   modport master (
      output flush, alloc_req, alloc_pc,
      output wb0_valid, wb0_index, wb0_val, wb0_rd, wb0_write,
      output wb1_valid, wb1_index, wb1_val, wb1_rd, wb1_write,
      output lookup_rd,
      input  alloc_ready, alloc_index,
      input  commit_valid, commit_rd, commit_val, commit_write, commit_pc,
      input  lookup_hit, lookup_val, count
   );

   modport slave (
      input  flush, alloc_req, alloc_pc,
      input  wb0_valid, wb0_index, wb0_val, wb0_rd, wb0_write,
      input  wb1_valid, wb1_index, wb1_val, wb1_rd, wb1_write,
      input  lookup_rd,
      output alloc_ready, alloc_index,
      output commit_valid, commit_rd, commit_val, commit_write, commit_pc,
      output lookup_hit, lookup_val, count
   );
endinterface

// File: rtl/rob_lookup.sv
// Bypass search over the reorder buffer: youngest busy+done+write entry whose rd matches wins.
module rob_lookup
   import rob_pkg::*;
#(
   parameter int ENTRIES = ROB_ENTRIES,
   parameter int IDX_W   = ROB_IDX_W,
   parameter int DATA_W  = ROB_DATA_W
) (
   input  rob_entry_t              entries [ENTRIES],
   input  logic [IDX_W-1:0]        tail,
   input  logic [ROB_RD_W-1:0]     lookup_rd,
   output logic                    hit,
   output logic [DATA_W-1:0]       val
);
   logic [IDX_W-1:0] idx;
   logic             unused_pc;

   always_comb begin
      hit       = 1'b0;
      val       = '0;
      idx       = '0;
      unused_pc = 1'b0;
      // Walk oldest to youngest starting at tail, so the last match standing is the youngest.
      for (int i = 0; i < ENTRIES; i++) begin
         idx       = tail + IDX_W'(i);
         unused_pc = unused_pc ^ (^entries[idx].pc);
         if (entries[idx].busy && entries[idx].done && entries[idx].write &&
             (entries[idx].rd == lookup_rd) && (lookup_rd != '0)) begin
            hit = 1'b1;
            val = entries[idx].val;
         end
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// Eight-entry in-order commit buffer with two out-of-order writeback ports.
// Optional bypass search over completed entries is built only when ROB_BYPASS_EN is defined.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int ENTRIES = ROB_ENTRIES,
   parameter int IDX_W   = ROB_IDX_W,
   parameter int DATA_W  = ROB_DATA_W
) (
   input  logic           clk,
   input  logic           reset,
   reorder_buffer_if.slave rif
);
   rob_entry_t            entry_q [ENTRIES];
   rob_entry_t            entry_d [ENTRIES];
   logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [IDX_W:0]        count_q, count_d;
   logic                  commit_valid_q, commit_valid_d;
   logic [ROB_RD_W-1:0]   commit_rd_q, commit_rd_d;
   logic [DATA_W-1:0]     commit_val_q, commit_val_d;
   logic                  commit_write_q, commit_write_d;
   logic [DATA_W-1:0]     commit_pc_q, commit_pc_d;
   logic                  alloc_ready, do_alloc, do_commit, wb0_ok, wb1_ok;

   // Ready looks only at registered occupancy, never at this cycle's commit.
   assign alloc_ready = (count_q != (IDX_W+1)'(ENTRIES));
   assign do_alloc    = rif.alloc_req && alloc_ready;
   assign do_commit   = entry_q[head_q].busy && entry_q[head_q].done;
   assign wb0_ok      = rif.wb0_valid && entry_q[rif.wb0_index].busy && !entry_q[rif.wb0_index].done;
   assign wb1_ok      = rif.wb1_valid && entry_q[rif.wb1_index].busy && !entry_q[rif.wb1_index].done &&
                        !(wb0_ok && (rif.wb0_index == rif.wb1_index));

   always_comb begin
      entry_d        = entry_q;
      head_d         = head_q;
      tail_d         = tail_q;
      commit_valid_d = 1'b0;
      commit_rd_d    = commit_rd_q;
      commit_val_d   = commit_val_q;
      commit_write_d = commit_write_q;
      commit_pc_d    = commit_pc_q;
      if (wb0_ok) begin
         entry_d[rif.wb0_index].val   = rif.wb0_val;
         entry_d[rif.wb0_index].rd    = rif.wb0_rd;
         entry_d[rif.wb0_index].write = rif.wb0_write;
         entry_d[rif.wb0_index].done  = 1'b1;
      end
      if (wb1_ok) begin
         entry_d[rif.wb1_index].val   = rif.wb1_val;
         entry_d[rif.wb1_index].rd    = rif.wb1_rd;
         entry_d[rif.wb1_index].write = rif.wb1_write;
         entry_d[rif.wb1_index].done  = 1'b1;
      end
      if (do_commit) begin
         commit_valid_d         = 1'b1;
         commit_rd_d            = entry_q[head_q].rd;
         commit_val_d           = entry_q[head_q].val;
         commit_write_d         = entry_q[head_q].write;
         commit_pc_d            = entry_q[head_q].pc;
         entry_d[head_q].busy   = 1'b0;
         entry_d[head_q].done   = 1'b0;
         head_d                 = head_q + IDX_W'(1);
      end
      if (do_alloc) begin
         entry_d[tail_q].busy = 1'b1;
         entry_d[tail_q].done = 1'b0;
         entry_d[tail_q].pc   = rif.alloc_pc;
         tail_d               = tail_q + IDX_W'(1);
      end
      count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
      // Flush overrides everything decided above in the same cycle.
      if (rif.flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_d[i].busy = 1'b0;
            entry_d[i].done = 1'b0;
         end
         head_d         = '0;
         tail_d         = '0;
         count_d        = '0;
         commit_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_val_q   <= '0;
         commit_write_q <= 1'b0;
         commit_pc_q    <= '0;
      end else begin
         entry_q        <= entry_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_val_q   <= commit_val_d;
         commit_write_q <= commit_write_d;
         commit_pc_q    <= commit_pc_d;
      end
   end

   assign rif.alloc_ready  = alloc_ready;
   assign rif.alloc_index  = tail_q;
   assign rif.count        = count_q;
   assign rif.commit_valid = commit_valid_q;
   assign rif.commit_rd    = commit_rd_q;
   assign rif.commit_val   = commit_val_q;
   assign rif.commit_write = commit_write_q;
   assign rif.commit_pc    = commit_pc_q;

`ifdef ROB_BYPASS_EN
   rob_lookup #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W),
      .DATA_W  (DATA_W)
   ) u_lookup (
      .entries   (entry_q),
      .tail      (tail_q),
      .lookup_rd (rif.lookup_rd),
      .hit       (rif.lookup_hit),
      .val       (rif.lookup_val)
   );
`else
   logic [ROB_RD_W-1:0] unused_lookup_rd;
   assign unused_lookup_rd = rif.lookup_rd;
   assign rif.lookup_hit   = 1'b0;
   assign rif.lookup_val   = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: expected retirements are queued at allocation and matched as commits appear.
module tb_reorder_buffer;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] val;
      logic [4:0]  rd;
      logic        wr;
   } exp_t;

`ifdef ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   int          checks;
   int          failures;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] slot_val [8];
   logic [4:0]  slot_rd  [8];
   logic        slot_wr  [8];

   reorder_buffer_if #(.IDX_W(3), .DATA_W(32)) rif ();

   reorder_buffer dut (
      .clk   (clk),
      .reset (reset),
      .rif   (rif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && rif.commit_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL commit_unexpected got pc=%h val=%h required no commit", rif.commit_pc, rif.commit_val);
         end else begin
            mon_e = exp_q.pop_front();
            if (rif.commit_pc !== mon_e.pc || rif.commit_val !== mon_e.val ||
                rif.commit_rd !== mon_e.rd || rif.commit_write !== mon_e.wr) begin
               failures++;
               $display("FAIL commit_fields got pc=%h val=%h rd=%0d w=%b required pc=%h val=%h rd=%0d w=%b",
                        rif.commit_pc, rif.commit_val, rif.commit_rd, rif.commit_write,
                        mon_e.pc, mon_e.val, mon_e.rd, mon_e.wr);
            end
         end
      end
   end

   task automatic idle();
      rif.flush = 0; rif.alloc_req = 0; rif.alloc_pc = '0; rif.lookup_rd = '0;
      rif.wb0_valid = 0; rif.wb0_index = '0; rif.wb0_val = '0; rif.wb0_rd = '0; rif.wb0_write = 0;
      rif.wb1_valid = 0; rif.wb1_index = '0; rif.wb1_val = '0; rif.wb1_rd = '0; rif.wb1_write = 0;
   endtask

   task automatic alloc(input logic [31:0] pc, input logic [31:0] val, input logic [4:0] rd,
                        input logic wr, output logic [2:0] idx);
      exp_t e;
      idx = rif.alloc_index;
      slot_val[idx] = val; slot_rd[idx] = rd; slot_wr[idx] = wr;
      e.pc = pc; e.val = val; e.rd = rd; e.wr = wr;
      exp_q.push_back(e);
      rif.alloc_req = 1; rif.alloc_pc = pc;
      @(negedge clk);
      rif.alloc_req = 0;
   endtask

   task automatic wb(input int port, input logic [2:0] idx);
      if (port == 0) begin
         rif.wb0_valid = 1; rif.wb0_index = idx; rif.wb0_val = slot_val[idx];
         rif.wb0_rd = slot_rd[idx]; rif.wb0_write = slot_wr[idx];
      end else begin
         rif.wb1_valid = 1; rif.wb1_index = idx; rif.wb1_val = slot_val[idx];
         rif.wb1_rd = slot_rd[idx]; rif.wb1_write = slot_wr[idx];
      end
      @(negedge clk);
      rif.wb0_valid = 0; rif.wb1_valid = 0;
   endtask

   task automatic flush_pulse();
      rif.flush = 1;
      exp_q.delete();
      @(negedge clk);
      rif.flush = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle();
      repeat (2) @(negedge clk);
      checks++; if (rif.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", rif.alloc_ready); end
      checks++; if (rif.alloc_index !== 3'd0) begin failures++; $display("FAIL reset_index got=%0d required=0", rif.alloc_index); end
      checks++; if (rif.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d required=0", rif.count); end
      checks++; if (rif.commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b required=0", rif.commit_valid); end
      checks++; if (rif.lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b required=0", rif.lookup_hit); end
      reset = 0;
      @(negedge clk);
   endtask

   task automatic test_in_order();
      logic [2:0] idx;
      checks++; if (rif.alloc_index !== 3'd0) begin failures++; $display("FAIL inorder_idx0 got=%0d required=0", rif.alloc_index); end
      alloc(32'h0, 32'h1000, 5'd1, 1'b1, idx);
      alloc(32'h4, 32'h2004, 5'd2, 1'b1, idx);
      alloc(32'h8, 32'h3008, 5'd3, 1'b0, idx);
      checks++; if (rif.count !== 4'd3) begin failures++; $display("FAIL inorder_count got=%0d required=3", rif.count); end
      wb(0, 3'd2);
      wb(0, 3'd0);
      checks++; if (rif.commit_valid !== 1'b0) begin failures++; $display("FAIL inorder_early got=%b required=0", rif.commit_valid); end
      wb(0, 3'd1);
      checks++; if (rif.commit_valid !== 1'b1 || rif.commit_pc !== 32'h0) begin failures++; $display("FAIL inorder_first got v=%b pc=%h required v=1 pc=0", rif.commit_valid, rif.commit_pc); end
      @(negedge clk);
      checks++; if (rif.commit_valid !== 1'b1 || rif.commit_pc !== 32'h4) begin failures++; $display("FAIL inorder_second got v=%b pc=%h required v=1 pc=4", rif.commit_valid, rif.commit_pc); end
      @(negedge clk);
      checks++; if (rif.commit_valid !== 1'b1 || rif.commit_pc !== 32'h8) begin failures++; $display("FAIL inorder_third got v=%b pc=%h required v=1 pc=8", rif.commit_valid, rif.commit_pc); end
      @(negedge clk);
      checks++; if (rif.count !== 4'd0 || rif.commit_valid !== 1'b0) begin failures++; $display("FAIL inorder_empty got cnt=%0d v=%b required cnt=0 v=0", rif.count, rif.commit_valid); end
   endtask

   task automatic test_full();
      logic [2:0] idx;
      int n;
      flush_pulse();
      for (int i = 0; i < 8; i++) begin
         checks++; if (rif.alloc_index !== 3'(i)) begin failures++; $display("FAIL full_idx got=%0d required=%0d", rif.alloc_index, i); end
         alloc(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 5'(i + 1), 1'b1, idx);
      end
      checks++; if (rif.count !== 4'd8 || rif.alloc_ready !== 1'b0) begin failures++; $display("FAIL full_state got cnt=%0d rdy=%b required cnt=8 rdy=0", rif.count, rif.alloc_ready); end
      rif.alloc_req = 1; rif.alloc_pc = 32'hDEAD;
      @(negedge clk);
      rif.alloc_req = 0;
      checks++; if (rif.count !== 4'd8 || rif.alloc_index !== 3'd0) begin failures++; $display("FAIL full_ninth got cnt=%0d idx=%0d required cnt=8 idx=0", rif.count, rif.alloc_index); end
      wb(0, 3'd0);
      checks++; if (rif.alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready_early got=%b required=0", rif.alloc_ready); end
      @(negedge clk);
      checks++; if (rif.commit_valid !== 1'b1 || rif.alloc_ready !== 1'b1 || rif.count !== 4'd7 || rif.alloc_index !== 3'd0)
         begin failures++; $display("FAIL full_release got v=%b rdy=%b cnt=%0d idx=%0d required v=1 rdy=1 cnt=7 idx=0", rif.commit_valid, rif.alloc_ready, rif.count, rif.alloc_index); end
      alloc(32'h200, 32'hB200, 5'd9, 1'b1, idx);
      for (int k = 1; k <= 8; k++) wb(0, 3'(k));
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain pending=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_same_index();
      logic [2:0] idx;
      int n;
      flush_pulse();
      for (int i = 0; i < 3; i++) alloc(32'h300 + 32'(4 * i), 32'hC000 + 32'(i), 5'd4, 1'b1, idx);
      alloc(32'h30C, 32'hAAAA, 5'd3, 1'b1, idx);
      rif.wb0_valid = 1; rif.wb0_index = 3'd3; rif.wb0_val = 32'hAAAA; rif.wb0_rd = 5'd3; rif.wb0_write = 1;
      rif.wb1_valid = 1; rif.wb1_index = 3'd3; rif.wb1_val = 32'hBBBB; rif.wb1_rd = 5'd3; rif.wb1_write = 1;
      @(negedge clk);
      rif.wb0_valid = 0; rif.wb1_val = 32'hCCCC;
      @(negedge clk);
      rif.wb1_valid = 0;
      wb(0, 3'd0); wb(0, 3'd1); wb(0, 3'd2);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL same_drain pending=%0d required=0", exp_q.size()); end
      // Writeback into a free slot must be dropped; the slot is then allocated with its own value.
      rif.wb0_valid = 1; rif.wb0_index = 3'd4; rif.wb0_val = 32'h999; rif.wb0_rd = 5'd6; rif.wb0_write = 1;
      @(negedge clk);
      rif.wb0_valid = 0;
      alloc(32'h400, 32'h4444, 5'd6, 1'b1, idx);
      repeat (3) @(negedge clk);
      checks++; if (rif.count !== 4'd1) begin failures++; $display("FAIL stale_wb_count got=%0d required=1", rif.count); end
      wb(0, idx);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stale_wb_drain pending=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_flush();
      logic [2:0] idx [5];
      logic [2:0] i0;
      int n;
      for (int i = 0; i < 5; i++) alloc(32'h800 + 32'(4 * i), 32'hD000 + 32'(i), 5'd7, 1'b1, idx[i]);
      wb(0, idx[1]);
      wb(1, idx[2]);
      rif.flush = 1; rif.alloc_req = 1; rif.alloc_pc = 32'hF00;
      rif.wb0_valid = 1; rif.wb0_index = idx[0]; rif.wb0_val = 32'hF0F0; rif.wb0_rd = 5'd7; rif.wb0_write = 1;
      exp_q.delete();
      @(negedge clk);
      idle();
      checks++; if (rif.count !== 4'd0 || rif.alloc_index !== 3'd0 || rif.commit_valid !== 1'b0)
         begin failures++; $display("FAIL flush_state got cnt=%0d idx=%0d v=%b required cnt=0 idx=0 v=0", rif.count, rif.alloc_index, rif.commit_valid); end
      @(negedge clk);
      checks++; if (rif.commit_valid !== 1'b0 || rif.count !== 4'd0) begin failures++; $display("FAIL flush_after got v=%b cnt=%0d required v=0 cnt=0", rif.commit_valid, rif.count); end
      alloc(32'h500, 32'h5555, 5'd7, 1'b1, i0);
      checks++; if (i0 !== 3'd0) begin failures++; $display("FAIL flush_tail got=%0d required=0", i0); end
      wb(0, i0);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL flush_head pending=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_async_reset();
      logic [2:0] ia, ib;
      int n;
      alloc(32'h600, 32'h6666, 5'd8, 1'b1, ia);
      alloc(32'h604, 32'h7777, 5'd9, 1'b1, ib);
      wb(0, ia);
      n = 0;
      while (rif.commit_valid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
      checks++; if (rif.commit_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got v=%b required=1", rif.commit_valid); end
      #2 reset = 1;
      #1;
      checks++; if (rif.commit_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b required=0", rif.commit_valid); end
      checks++; if (rif.commit_pc !== 32'h0 || rif.commit_val !== 32'h0 || rif.commit_rd !== 5'd0 || rif.commit_write !== 1'b0)
         begin failures++; $display("FAIL areset_fields got pc=%h val=%h rd=%0d w=%b required all 0", rif.commit_pc, rif.commit_val, rif.commit_rd, rif.commit_write); end
      checks++; if (rif.count !== 4'd0 || rif.alloc_ready !== 1'b1 || rif.alloc_index !== 3'd0)
         begin failures++; $display("FAIL areset_ctrl got cnt=%0d rdy=%b idx=%0d required cnt=0 rdy=1 idx=0", rif.count, rif.alloc_ready, rif.alloc_index); end
      exp_q.delete();
      @(negedge clk);
      reset = 0;
      @(negedge clk);
   endtask

   task automatic test_bypass();
      logic [2:0] idx;
      int n;
      alloc(32'h700, 32'h10, 5'd2, 1'b1, idx);
      alloc(32'h704, 32'h11, 5'd5, 1'b1, idx);
      alloc(32'h708, 32'h22, 5'd5, 1'b0, idx);
      alloc(32'h70C, 32'h33, 5'd0, 1'b1, idx);
      alloc(32'h710, 32'h44, 5'd5, 1'b1, idx);
      wb(0, 3'd1); wb(1, 3'd2); wb(0, 3'd3);
      rif.lookup_rd = 5'd5; #1;
      checks++; if (rif.lookup_hit !== BYP || rif.lookup_val !== (BYP ? 32'h11 : 32'h0))
         begin failures++; $display("FAIL bypass_older got hit=%b val=%h required hit=%b val=%h", rif.lookup_hit, rif.lookup_val, BYP, BYP ? 32'h11 : 32'h0); end
      @(negedge clk);
      wb(0, 3'd4);
      #1;
      checks++; if (rif.lookup_hit !== BYP || rif.lookup_val !== (BYP ? 32'h44 : 32'h0))
         begin failures++; $display("FAIL bypass_youngest got hit=%b val=%h required hit=%b val=%h", rif.lookup_hit, rif.lookup_val, BYP, BYP ? 32'h44 : 32'h0); end
      rif.lookup_rd = 5'd0; #1;
      checks++; if (rif.lookup_hit !== 1'b0) begin failures++; $display("FAIL bypass_rd0 got=%b required=0", rif.lookup_hit); end
      rif.lookup_rd = 5'd3; #1;
      checks++; if (rif.lookup_hit !== 1'b0) begin failures++; $display("FAIL bypass_miss got=%b required=0", rif.lookup_hit); end
      rif.lookup_rd = 5'd0;
      @(negedge clk);
      wb(0, 3'd0);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bypass_drain pending=%0d required=0", exp_q.size()); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_in_order();
      test_full();
      test_same_index();
      test_flush();
      test_async_reset();
      test_bypass();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Eight-entry in-order commit buffer that hands out the 3-bit `rob_index` carried down every pipeline register and collects results at the far end. Fetch allocates an index per instruction. Writebacks may arrive out of order from the fast path (C_WB stage) and the slow path (SLREG). Commit then retires results strictly in allocation order to the register file.

## Interface
- `ENTRIES`, 8: buffer depth; power of two.
- `IDX_W`, 3: index width, log2(ENTRIES).
- `DATA_W`, 32: value and pc width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  synchronous clear of all entries.
- `alloc_req`  in  1  fetch requests an index.
- `alloc_pc`  in  DATA_W  pc of allocating instruction.
- `alloc_ready`  out  1  buffer not full.
- `alloc_index`  out  IDX_W  index granted on this cycle (= tail).
- `wb0_valid` / `wb0_index` / `wb0_val` / `wb0_rd` / `wb0_write`  in  1/IDX_W/DATA_W/5/1  fast-path writeback.
- `wb1_valid` / `wb1_index` / `wb1_val` / `wb1_rd` / `wb1_write`  in  1/IDX_W/DATA_W/5/1  slow-path writeback.
- `commit_valid`  out  1  one-cycle retire pulse.
- `commit_rd`, `commit_val`, `commit_write`, `commit_pc`  out  5/DATA_W/1/DATA_W  retired entry.
- `lookup_rd`  in  5  operand register to search (bypass).
- `lookup_hit`, `lookup_val`  out  1/DATA_W  bypass result.
- `count`  out  IDX_W+1  occupied entries, 0..ENTRIES.

## Operation
- State: `head`, `tail` (IDX_W bits, wrap naturally), `count`; per entry `busy`, `done`, `pc`, `val`, `rd`, `write`.
- Allocate: if `alloc_req && alloc_ready`, set entry[tail] `busy=1`, `done=0`, store `pc`, then `tail++`.
- `alloc_ready = (count != ENTRIES)`. It is not relieved by a same-cycle commit, so there is no commit-to-fetch combinational path.
- Writeback: if `wbN_valid` and entry[`wbN_index`] is busy and not done, store `val`, `rd`, `write` and set `done=1`.
  - Writeback to a non-busy or already-done entry is ignored.
  - If both ports target the same index, `wb0` wins.
- Commit: if entry[head] is `busy && done`, register its fields to the `commit_*` outputs, pulse `commit_valid`, clear `busy`, and do `head++`.
  - At most one commit per cycle.
- `count` next = count + alloc − commit. Simultaneous alloc and commit leaves it unchanged.
- Flush: clears `busy`/`done` for all entries, sets head=tail=count=0, and deasserts `commit_valid` next cycle.
  - Flush has priority over alloc, writeback and commit in the same cycle.
- Reset: same as flush, asynchronously. All outputs are 0 except `alloc_ready`=1; `alloc_index`=0.

## Timing
- `alloc_index` and `alloc_ready` are combinational from registered state. The index is valid during the cycle the request is sampled.
- Writeback sampled at edge N sets `done`. The earliest commit pulse is registered at edge N+1 (visible cycle N+1..N+2).
- Back-to-back completed entries retire one per cycle.
- Full: 8 allocations with no commit leaves `count=8` and `alloc_ready=0`. The first commit restores ready the following cycle.
- Empty: `commit_valid=0`; a head that is not busy never commits.
- `head` and `tail` wrap 7→0 without special handling.

## Configuration
- `ROB_BYPASS_EN` defined: `lookup_hit`/`lookup_val` are combinational.
  - Search all `busy && done && write` entries with `rd == lookup_rd`. The youngest match (closest to tail) wins.
  - `lookup_rd == 0` never hits.
- Undefined: ports remain, with `lookup_hit=0` and `lookup_val=0`. No search logic is built.

## Structure
- Shared package `rob_pkg`: `ROB_ENTRIES`, `ROB_IDX_W`, `rob_entry_t` (busy, done, pc, val, rd, write).
- One sub-module `rob_lookup`: age-ordered youngest-match priority search, instantiated only under `ROB_BYPASS_EN`.

## Test plan
- Allocate pcs 0x0,0x4,0x8; `wb0` to indices 2,0,1 on successive cycles. Required: commits pcs 0x0,0x4,0x8 in order, index 0 committing the cycle after its writeback.
- Allocate 8 with no writeback. Required: `count=8`, `alloc_ready=0`, and a 9th `alloc_req` is ignored. Then writeback index 0. Required: commit, and `alloc_ready=1` one cycle later; next `alloc_index=0` (wrap).
- `wb0` and `wb1` to index 3 in the same cycle with values 0xAAAA / 0xBBBB. Required: committed `val=0xAAAA`. A later `wb1` to index 3 is ignored.
- Flush with 5 entries busy and concurrent `alloc_req` and writeback. Required: `count=0`, head=tail=0, no commit pulse next cycle.
- Assert `reset` mid-cycle while `commit_valid=1`. Required: all outputs 0 immediately (`alloc_ready=1`), without waiting for a clock edge.
- With `ROB_BYPASS_EN`: entries 1 and 4 both done with `rd=5` (vals 0x11, 0x44), head=0, `lookup_rd=5`. Required: hit with 0x44. `lookup_rd=0` required: no hit.
